// File: rtl/tx_arbiter_pkg.sv
// rtl/tx_arbiter_pkg.sv - shared state encoding and source indices for the Tx link arbiter
package tx_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   localparam int SRC_TRIG_STATUS = 0;
   localparam int SRC_CH1         = 1;
   localparam int SRC_CH2         = 2;
   localparam int N_SRC_DEFAULT   = SRC_CH2 + 1;

   // Index width that stays legal for a single-source build.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting after the last owner
module rr_picker
   import tx_arbiter_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEFAULT,
   localparam int IDX_W = idx_width(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [N_SRC-1:0] pick,
   output logic             valid
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      pick  = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 1; i <= N_SRC; i++) begin
         idx = IDX_W'((int'(last) + i) % N_SRC);
         if (!valid && req[idx]) begin
            pick[idx] = 1'b1;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - frame-level round-robin arbiter sharing the byte-wide Tx link
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int N_SRC      = N_SRC_DEFAULT,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_SRC*DATA_WIDTH-1:0] src_data,
   input  logic [N_SRC-1:0]            src_rdy,
   input  logic [N_SRC-1:0]            src_eof,
   output logic [N_SRC-1:0]            src_ack,
   output logic [DATA_WIDTH-1:0]       tx_data,
   output logic                        tx_rdy,
   output logic                        tx_eof,
   input  logic                        tx_ack,
   output logic [N_SRC-1:0]            grant,
   output logic                        timeout_err
);

   localparam int IDX_W = idx_width(N_SRC);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   arb_state_t       state, state_nxt;
   logic [N_SRC-1:0] grant_nxt, pick;
   logic             pick_valid;
   logic [IDX_W-1:0] last, last_nxt, owner;
   logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt, stall_inc;
   logic             timeout_nxt, active, owner_rdy, xfer_eof;

   rr_picker #(.N_SRC(N_SRC)) u_picker (
      .req   (src_rdy),
      .last  (last),
      .pick  (pick),
      .valid (pick_valid)
   );

   always_comb begin
      owner = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant[i]) owner = IDX_W'(i);
      end
   end

   // Gating with rst keeps a mid-frame reset cycle from acking the source.
   assign active    = (state == ST_BUSY) && !rst;
   assign owner_rdy = src_rdy[owner];
   assign tx_rdy    = active & owner_rdy;
   assign tx_eof    = active & src_eof[owner];
   assign tx_data   = active ? src_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign xfer_eof  = tx_rdy & tx_ack & tx_eof;
   assign stall_inc = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + CNT_W'(1);

   always_comb begin
      src_ack = '0;
      if (active) src_ack[owner] = tx_ack & owner_rdy;
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      last_nxt      = last;
      stall_cnt_nxt = stall_cnt;
      timeout_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            stall_cnt_nxt = '0;
            if (pick_valid) begin
               grant_nxt = pick;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // EOF is checked first so it always beats a coincident timeout.
            if (xfer_eof) begin
               state_nxt     = ST_IDLE;
               grant_nxt     = '0;
               last_nxt      = owner;
               stall_cnt_nxt = '0;
            end else if (owner_rdy) begin
               stall_cnt_nxt = '0;
            end else if ((TIMEOUT > 0) && (stall_inc == CNT_W'(TIMEOUT))) begin
               timeout_nxt   = 1'b1;
               state_nxt     = ST_IDLE;
               grant_nxt     = '0;
               last_nxt      = owner;
               stall_cnt_nxt = '0;
            end else begin
               stall_cnt_nxt = stall_inc;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         grant       <= '0;
         last        <= IDX_W'(N_SRC - 1);
         stall_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         last        <= last_nxt;
         stall_cnt   <= stall_cnt_nxt;
         timeout_err <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - scoreboard bench for the Tx link arbiter
module tb_tx_arbiter;
   import tx_arbiter_pkg::*;

   logic        clk, rst, tx_ack, tx_rdy, tx_eof, timeout_err;
   logic [23:0] src_data;
   logic [2:0]  src_rdy, src_eof, src_ack, grant;
   logic [7:0]  tx_data;

   tx_arbiter #(.N_SRC(3), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .src_data(src_data), .src_rdy(src_rdy), .src_eof(src_eof),
      .src_ack(src_ack), .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_eof(tx_eof),
      .tx_ack(tx_ack), .grant(grant), .timeout_err(timeout_err)
   );

   typedef struct {
      int         src;
      logic [7:0] data;
      logic       eof;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] sq0[$], sq1[$], sq2[$];
   int         xfer_cyc[$];
   int         tests_run = 0, tests_failed = 0, cyc = 0, tmo_count = 0;
   logic [2:0] acked = '0;
   logic       prev_eof = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic src_push(input int s, input logic [7:0] base, input int len, input logic eof_last);
      logic [8:0] it;
      for (int i = 0; i < len; i++) begin
         it = {eof_last && (i == len - 1), base + 8'(i)};
         case (s)
            0:       sq0.push_back(it);
            1:       sq1.push_back(it);
            default: sq2.push_back(it);
         endcase
      end
   endtask

   task automatic exp_push(input int s, input logic [7:0] base, input int len, input logic eof_last);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         e.src  = s;
         e.data = base + 8'(i);
         e.eof  = eof_last && (i == len - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && grant == 3'b000) break;
      end
      check_eq("drain", exp_q.size(), 0);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Source models: present queue head until acked.
   initial begin
      src_rdy = '0; src_eof = '0; src_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (acked[0] && sq0.size() > 0) void'(sq0.pop_front());
         if (acked[1] && sq1.size() > 0) void'(sq1.pop_front());
         if (acked[2] && sq2.size() > 0) void'(sq2.pop_front());
         src_rdy[0] = sq0.size() > 0;
         src_rdy[1] = sq1.size() > 0;
         src_rdy[2] = sq2.size() > 0;
         {src_eof[0], src_data[7:0]}   = (sq0.size() > 0) ? sq0[0] : 9'h0;
         {src_eof[1], src_data[15:8]}  = (sq1.size() > 0) ? sq1[0] : 9'h0;
         {src_eof[2], src_data[23:16]} = (sq2.size() > 0) ? sq2[0] : 9'h0;
      end
   end

   // Monitor: scoreboard on every Tx byte, ack and frame-gap checks.
   initial begin
      exp_t        e;
      logic [31:0] exp_ack;
      forever begin
         @(negedge clk);
         acked = src_ack;
         if (timeout_err) tmo_count++;
         if (prev_eof) check_eq("gap_grant", grant, 0);
         prev_eof = 1'b0;
         exp_ack = (tx_rdy && tx_ack) ? 32'(grant) : 32'h0;
         check_eq("src_ack", src_ack, exp_ack);
         if (tx_rdy) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_rdy", tx_rdy, 0);
            end else begin
               e = exp_q[0];
               check_eq("byte_grant", grant, 32'h1 << e.src);
               check_eq("byte_data", tx_data, e.data);
               if (tx_ack) begin
                  check_eq("byte_eof", tx_eof, e.eof);
                  void'(exp_q.pop_front());
                  xfer_cyc.push_back(cyc);
                  prev_eof = tx_eof;
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap_tab[5];
      int base;
      gap_tab = '{1, 2, 1, 2, 1};
      rst = 1'b1;
      tx_ack = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_grant", grant, 0);
      check_eq("rst_tx_rdy", tx_rdy, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_timeout", timeout_err, 0);
      tick();
      rst = 1'b0;
      tick();

      // Single source, 4-byte frame, grant latency
      src_push(SRC_CH1, 8'h10, 4, 1'b1);
      exp_push(SRC_CH1, 8'h10, 4, 1'b1);
      tick();
      check_eq("lat_idle", grant, 0);
      tick();
      check_eq("lat_grant", grant, 3'b010);
      check_eq("lat_data", tx_data, 8'h10);
      wait_drain();

      // All three at once from reset: order 0,1,2 with one idle cycle between frames
      do_reset();
      base = xfer_cyc.size();
      src_push(0, 8'h20, 2, 1'b1); src_push(1, 8'h30, 2, 1'b1); src_push(2, 8'h40, 2, 1'b1);
      exp_push(0, 8'h20, 2, 1'b1); exp_push(1, 8'h30, 2, 1'b1); exp_push(2, 8'h40, 2, 1'b1);
      wait_drain();
      for (int i = 1; i < 6; i++) begin
         if (xfer_cyc.size() > base + i)
            check_eq("rr_spacing", xfer_cyc[base + i] - xfer_cyc[base + i - 1], gap_tab[i - 1]);
         else
            check_eq("rr_count", xfer_cyc.size() - base, 6);
      end

      // Backpressure: tx_ack alternates
      base = xfer_cyc.size();
      src_push(0, 8'h60, 3, 1'b1);
      exp_push(0, 8'h60, 3, 1'b1);
      for (int k = 0; k < 12; k++) begin
         tick();
         tx_ack = (k % 2) == 0;
      end
      tx_ack = 1'b1;
      wait_drain();
      check_eq("bp_count", xfer_cyc.size() - base, 3);

      // Timeout: src 2 stalls after one byte, pending src 0 follows
      src_push(2, 8'hA0, 1, 1'b0);
      exp_push(2, 8'hA0, 1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sq2.size() == 0) break;
      end
      check_eq("tmo_start", sq2.size(), 0);
      src_push(0, 8'hB0, 2, 1'b1);
      exp_push(0, 8'hB0, 2, 1'b1);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         check_eq("tmo_pulse", timeout_err, k == 4);
         check_eq("tmo_grant", grant, (k == 4) ? 3'b000 : 3'b100);
         if (k < 4) @(posedge clk);
      end
      tick();
      check_eq("tmo_next", grant, 3'b001);
      wait_drain();

      // Fairness: src 1 requests mid-frame while src 0 streams continuously
      src_push(0, 8'h70, 3, 1'b1);
      src_push(0, 8'h80, 3, 1'b1);
      exp_push(0, 8'h70, 3, 1'b1);
      exp_push(1, 8'h90, 2, 1'b1);
      exp_push(0, 8'h80, 3, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (grant == 3'b001) break;
      end
      check_eq("fair_grant0", grant, 3'b001);
      src_push(1, 8'h90, 2, 1'b1);
      wait_drain();

      // Reset during byte 2 of a 5-byte frame
      src_push(0, 8'h50, 5, 1'b1);
      exp_push(0, 8'h50, 5, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (grant == 3'b001 && tx_data == 8'h52) break;
      end
      check_eq("mid_byte2", tx_data, 8'h52);
      rst = 1'b1;
      src_push(1, 8'hC0, 2, 1'b1);
      exp_push(1, 8'hC0, 2, 1'b1);
      @(negedge clk);
      check_eq("mid_rst_ack", src_ack, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_grant", grant, 0);
      check_eq("mid_tx_rdy", tx_rdy, 0);
      check_eq("mid_tx_data", tx_data, 0);
      check_eq("mid_src_ack", src_ack, 0);
      tick();
      check_eq("mid_rearb", grant, 3'b001);
      wait_drain();

      check_eq("tmo_total", tmo_count, 1);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
